adder_arbiter: RTL and testbench

- Shares one `adder` datapath instance among NUM_REQ requesters.
- Round-robin arbitration picks at most one operand pair per cycle and issues it to the adder.
- An ID/valid tag pipeline runs alongside the adder; results are broadcast with the originating requester ID.
- Sits between several add-requesting clients and a single adder; sustains one add per cycle.

---
 rtl/adder_arbiter.sv | 165 ++++++++++++++++
 tb/tb_adder_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: lets NUM_REQ requesters share one adder pipeline.
//
// A round-robin arbiter grants at most one requester per cycle. The granted
// operand pair goes into the adder, and a {valid, id} tag pipeline of the
// same depth runs beside it. Each result comes out with the index of the
// requester that issued it.
//
// Handshake: requester i transfers in any cycle where req_valid[i] and
// req_ready[i] are both high. A raised req_valid holds, with its operands
// stable, until that transfer. req_valid never depends combinationally on
// req_ready. The response side has no backpressure: rsp_valid pulses for
// exactly one cycle per accepted op.
//
// Ports:
//   clk, rst      clock; synchronous active-high reset
//   req_valid     per-requester request valid        [NUM_REQ]
//   req_ready     one-hot grant, or zero             [NUM_REQ]
//   req_in0/in1   packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid     result valid, LATENCY cycles after the transfer
//   rsp_id        requester index of the result      [IDW]
//   rsp_sum       (in0 + in1) mod 2^WIDTH            [WIDTH]
//   busy          an accepted op is still in flight

// Adder with optional input and output register stages. The data registers
// have no reset; the valid tags carried beside them qualify every result.
module adder #(
  parameter int WIDTH           = 8,
  parameter bit REGISTER_INPUT  = 1'b1,
  parameter bit REGISTER_OUTPUT = 1'b1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum
);
  logic [WIDTH-1:0] a_s, b_s, sum_c;

  generate
    if (REGISTER_INPUT) begin : g_in_reg
      always_ff @(posedge clk) begin
        a_s <= a;
        b_s <= b;
      end
    end else begin : g_in_comb
      assign a_s = a;
      assign b_s = b;
    end
  endgenerate

  // The carry-out is dropped, so the sum wraps around.
  assign sum_c = a_s + b_s;

  generate
    if (REGISTER_OUTPUT) begin : g_out_reg
      always_ff @(posedge clk) sum <= sum_c;
    end else begin : g_out_comb
      assign sum = sum_c;
    end
  endgenerate
endmodule

module adder_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int LATENCY = 2,
  localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_in0,
  input  logic [NUM_REQ*WIDTH-1:0] req_in1,
  output logic                     rsp_valid,
  output logic [IDW-1:0]           rsp_id,
  output logic [WIDTH-1:0]         rsp_sum,
  output logic                     busy
);
  logic [IDW-1:0]     rr_ptr;
  logic [IDW-1:0]     grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               grant_any;
  logic [WIDTH-1:0]   op_a, op_b;
  int                 scan;

  // Scan from rr_ptr upward, wrapping modulo NUM_REQ. The first valid
  // requester found gets the grant.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    scan      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = int'(rr_ptr) + k;
      if (scan >= NUM_REQ) scan = scan - NUM_REQ;
      if (!grant_any && req_valid[scan[IDW-1:0]]) begin
        grant_any                = 1'b1;
        grant_idx                = scan[IDW-1:0];
        grant[scan[IDW-1:0]]     = 1'b1;
      end
    end
    if (rst) begin
      grant     = '0;
      grant_any = 1'b0;
    end
  end

  assign req_ready = grant;

  // After a transfer, the next scan starts just past the winner.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
    end else if (grant_any) begin
      if (grant_idx == IDW'(NUM_REQ - 1)) rr_ptr <= '0;
      else                                rr_ptr <= grant_idx + IDW'(1);
    end
  end

  // With no grant, grant_idx is 0 and requester 0's operands pass through.
  // That slot's tag is invalid, so the value does not matter.
  assign op_a = req_in0[int'(grant_idx)*WIDTH +: WIDTH];
  assign op_b = req_in1[int'(grant_idx)*WIDTH +: WIDTH];

  adder #(
    .WIDTH          (WIDTH),
    .REGISTER_INPUT (LATENCY >= 1),
    .REGISTER_OUTPUT(LATENCY == 2)
  ) u_adder (
    .clk (clk),
    .a   (op_a),
    .b   (op_b),
    .sum (rsp_sum)
  );

  generate
    if (LATENCY == 0) begin : g_tag_comb
      assign rsp_valid = grant_any;
      assign rsp_id    = grant_idx;
      assign busy      = 1'b0;
    end else begin : g_tag_pipe
      logic [LATENCY-1:0] tag_valid;
      logic [IDW-1:0]     tag_id [LATENCY];

      // Only the valids are reset. Clearing them drops every in-flight op.
      always_ff @(posedge clk) begin
        if (rst) begin
          tag_valid <= '0;
        end else begin
          tag_valid[0] <= grant_any;
          for (int s = 1; s < LATENCY; s++) tag_valid[s] <= tag_valid[s-1];
        end
      end

      always_ff @(posedge clk) begin
        tag_id[0] <= grant_idx;
        for (int s = 1; s < LATENCY; s++) tag_id[s] <= tag_id[s-1];
      end

      assign rsp_valid = tag_valid[LATENCY-1];
      assign rsp_id    = tag_id[LATENCY-1];
      assign busy      = |tag_valid;
    end
  endgenerate
endmodule

// File: tb/tb_adder_arbiter.sv
// Bench for adder_arbiter. Instance dut is built with LATENCY=2 and dut0
// with LATENCY=0; both take the same requests. A behavioural model predicts
// the grant and the response stream of each instance every cycle.
module tb_adder_arbiter;
  localparam int N   = 4;
  localparam int W   = 8;
  localparam int IDW = 2;
  localparam int EW  = 32 + 8 + 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_in0 = '0, req_in1 = '0;
  logic [N-1:0]   req_ready, req_ready0;
  logic           rsp_valid, rsp_valid0, busy, busy0;
  logic [IDW-1:0] rsp_id, rsp_id0;
  logic [W-1:0]   rsp_sum, rsp_sum0;

  adder_arbiter #(.NUM_REQ(N), .WIDTH(W), .LATENCY(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_in0(req_in0), .req_in1(req_in1), .rsp_valid(rsp_valid),
    .rsp_id(rsp_id), .rsp_sum(rsp_sum), .busy(busy)
  );

  adder_arbiter #(.NUM_REQ(N), .WIDTH(W), .LATENCY(0)) dut0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready0),
    .req_in0(req_in0), .req_in1(req_in1), .rsp_valid(rsp_valid0),
    .rsp_id(rsp_id0), .rsp_sum(rsp_sum0), .busy(busy0)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic cyc_start;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_in0[i*W +: W] = a;
    req_in1[i*W +: W] = b;
  endtask

  function automatic logic [W-1:0] rand_op();
    return ($urandom_range(0, 3) == 0) ? W'(8'hFF) : W'($urandom_range(0, 255));
  endfunction

  // ---------------- model + scoreboard ----------------
  // Entries are {due_cycle, id, sum} for ops accepted but not yet answered.
  logic [EW-1:0] exp_q[$];
  int rr_m = 0;

  always @(negedge clk) begin
    int g, idx, sum_m;
    logic [EW-1:0] e;
    logic exp_v;
    g = -1;
    if (!rst) begin
      for (int k = 0; k < N; k++) begin
        idx = (rr_m + k) % N;
        if (g < 0 && req_valid[idx]) g = idx;
      end
    end
    sum_m = 0;
    if (g >= 0) sum_m = (int'(req_in0[g*W +: W]) + int'(req_in1[g*W +: W])) % 256;

    chk("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
    chk("req_ready_l0", 32'(req_ready0), (g >= 0) ? (32'd1 << g) : 32'd0);

    // Zero-latency instance answers in the transfer cycle itself.
    chk("rsp_valid_l0", 32'(rsp_valid0), 32'(g >= 0));
    chk("busy_l0", 32'(busy0), 32'd0);
    if (g >= 0) begin
      chk("rsp_id_l0", 32'(rsp_id0), 32'(g));
      chk("rsp_sum_l0", 32'(rsp_sum0), 32'(sum_m));
    end

    // Two-cycle instance
    chk("busy", 32'(busy), 32'(exp_q.size() > 0));
    exp_v = (exp_q.size() > 0) && (int'(exp_q[0][47:16]) == cyc);
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
    if (exp_v) begin
      e = exp_q.pop_front();
      chk("rsp_id", 32'(rsp_id), 32'(e[15:8]));
      chk("rsp_sum", 32'(rsp_sum), 32'(e[7:0]));
    end

    if (rst) begin
      exp_q.delete();
      rr_m = 0;
    end else if (g >= 0) begin
      exp_q.push_back({32'(cyc + 2), 8'(g), 8'(sum_m)});
      rr_m = (g + 1) % N;
    end
    cyc++;
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    logic [N-1:0] xf;

    // Reset
    repeat (3) begin
      cyc_start; mid;
      chk("reset_ready_lit", 32'(req_ready), 32'd0);
    end
    cyc_start; rst = 1'b0;
    mid;
    chk("post_reset_valid_lit", 32'(rsp_valid), 32'd0);
    chk("post_reset_busy_lit", 32'(busy), 32'd0);

    // Single request from requester 1
    cyc_start; set_req(1, 8'h12, 8'h34); req_valid = 4'b0010;
    mid; chk("single_grant_lit", 32'(req_ready), 32'h2);
    cyc_start; req_valid = '0;
    mid; chk("single_busy1_lit", 32'(busy), 32'd1);
    cyc_start;
    mid;
    chk("single_valid_lit", 32'(rsp_valid), 32'd1);
    chk("single_id_lit", 32'(rsp_id), 32'd1);
    chk("single_sum_lit", 32'(rsp_sum), 32'h46);
    chk("single_busy2_lit", 32'(busy), 32'd1);
    cyc_start;
    mid; chk("single_busy3_lit", 32'(busy), 32'd0);

    // Sum that wraps past 8 bits
    cyc_start; set_req(2, 8'hFF, 8'h02); req_valid = 4'b0100;
    mid; chk("wrap_grant_lit", 32'(req_ready), 32'h4);
    cyc_start; req_valid = '0;
    mid;
    cyc_start;
    mid;
    chk("wrap_sum_lit", 32'(rsp_sum), 32'h01);
    chk("wrap_id_lit", 32'(rsp_id), 32'd2);

    // Zero-latency instance
    cyc_start; set_req(3, 8'h80, 8'h80); req_valid = 4'b1000;
    mid;
    chk("l0_valid_lit", 32'(rsp_valid0), 32'd1);
    chk("l0_id_lit", 32'(rsp_id0), 32'd3);
    chk("l0_sum_lit", 32'(rsp_sum0), 32'h00);
    chk("l0_busy_lit", 32'(busy0), 32'd0);
    cyc_start; req_valid = '0;
    mid;

    // Pointer skip and wrap: get rr_ptr to 3, then only 0 and 2 request
    cyc_start; set_req(2, 8'h01, 8'h01); req_valid = 4'b0100;
    mid; chk("skip_setup_lit", 32'(req_ready), 32'h4);
    cyc_start; set_req(0, 8'h05, 8'h06); req_valid = 4'b0101;
    mid; chk("skip_first_lit", 32'(req_ready), 32'h1);
    cyc_start; req_valid = 4'b0100;
    mid; chk("skip_second_lit", 32'(req_ready), 32'h4);
    cyc_start; set_req(3, 8'h07, 8'h08); req_valid = 4'b1001;
    mid; chk("skip_ptr3_lit", 32'(req_ready), 32'h8);
    cyc_start; req_valid = '0;

    // Fairness: everyone valid from reset
    rst = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, rand_op(), rand_op());
    cyc_start; cyc_start;
    rst = 1'b0; req_valid = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      mid;
      chk("fair_grant_lit", 32'(req_ready), 32'd1 << (k % 4));
      if (k >= 2) begin
        chk("fair_rsp_valid_lit", 32'(rsp_valid), 32'd1);
        chk("fair_rsp_id_lit", 32'(rsp_id), 32'((k - 2) % 4));
      end
      cyc_start;
    end
    req_valid = '0;
    repeat (3) begin mid; cyc_start; end

    // Reset while ops are in flight
    set_req(1, 8'h11, 8'h22); req_valid = 4'b0010;
    mid; chk("rmf_issue_lit", 32'(req_ready), 32'h2);
    cyc_start; rst = 1'b1; set_req(2, 8'h33, 8'h44); req_valid = 4'b0110;
    mid; chk("rmf_rst_ready_lit", 32'(req_ready), 32'd0);
    cyc_start;
    mid;
    chk("rmf_busy_lit", 32'(busy), 32'd0);
    chk("rmf_valid2_lit", 32'(rsp_valid), 32'd0);
    cyc_start; rst = 1'b0;
    mid;
    chk("rmf_lowest_lit", 32'(req_ready), 32'h2);
    chk("rmf_valid3_lit", 32'(rsp_valid), 32'd0);
    cyc_start; req_valid = '0;
    mid; chk("rmf_valid4_lit", 32'(rsp_valid), 32'd0);

    // Random traffic that follows the handshake rules, with occasional resets
    for (int c = 0; c < 3000; c++) begin
      mid;
      xf = req_valid & req_ready;
      cyc_start;
      rst = ($urandom_range(0, 149) == 0);
      for (int i = 0; i < N; i++) begin
        if (req_valid[i]) begin
          if (xf[i]) begin
            if ($urandom_range(0, 3) == 0) req_valid[i] = 1'b0;
            else set_req(i, rand_op(), rand_op());
          end
        end else if ($urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          set_req(i, rand_op(), rand_op());
        end
      end
    end

    rst = 1'b0;
    req_valid = '0;
    repeat (5) begin mid; cyc_start; end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
